// File: rtl/seq_udiv_unmul.sv
// Multi-cycle radix-2 restoring unsigned divider (2W / W -> 2W quotient, W remainder).
// Ports: clk, rst (sync, active-high); in_valid/in_ready with dividend, divisor;
//        out_valid/out_ready with quotient, remainder, div_by_zero.
module seq_udiv_unmul #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2 * W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [2*W-1:0] q_reg;
    logic [W-1:0]   d_reg;
    logic [W-1:0]   r_reg;
    logic [CW-1:0]  cnt;

    logic [W:0]     r_t;
    logic [W:0]     diff;
    logic           ge;
    logic [2*W-1:0] q_next;
    logic [W-1:0]   r_next;

    // The partial remainder never exceeds the divisor, so W bits of state
    // suffice; the extra bit only exists in the shifted trial value.
    always_comb begin
        r_t    = {r_reg, q_reg[2*W-1]};
        diff   = r_t - {1'b0, d_reg};
        ge     = (r_t >= {1'b0, d_reg});
        q_next = {q_reg[2*W-2:0], ge};
        r_next = ge ? diff[W-1:0] : r_t[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg    <= dividend;
                        d_reg    <= divisor;
                        r_reg    <= '0;
                        cnt      <= CW'(2 * W - 1);
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // bvudiv/bvurem semantics for a zero divisor
                            quotient    <= '1;
                            remainder   <= dividend[W-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    if (cnt == '0) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_udiv_unmul.sv
// Directed and miter bench for seq_udiv_unmul at W=8 and W=64.
// Drives inputs 1ns after the rising edge and samples there too.
module tb_seq_udiv_unmul;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // W = 8 instance
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, dz8;
    logic [15:0] dd8 = '0, q8;
    logic [7:0]  dv8 = '0, r8;

    // W = 64 instance
    logic         iv64 = 1'b0, ir64, ov64, or64 = 1'b0, dz64;
    logic [127:0] dd64 = '0, q64;
    logic [63:0]  dv64 = '0, r64;

    int checks = 0;
    int failures = 0;

    seq_udiv_unmul #(.W(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .dividend(dd8), .divisor(dv8),
        .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    seq_udiv_unmul #(.W(64)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(iv64), .in_ready(ir64),
        .dividend(dd64), .divisor(dv64),
        .out_valid(ov64), .out_ready(or64),
        .quotient(q64), .remainder(r64), .div_by_zero(dz64)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one W=8 request and wait for the result; leaves DONE held.
    task automatic issue8(input logic [15:0] a, input logic [7:0] b,
                          output int lat);
        int n = 0;
        while (!ir8 && n < 50) begin
            tick();
            n++;
        end
        iv8 = 1'b1;
        dd8 = a;
        dv8 = b;
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [15:0] a,
                        input logic [7:0] b, input logic [15:0] eq,
                        input logic [7:0] er, input logic ez, input int el);
        int lat;
        issue8(a, b, lat);
        check({tag, ".lat"}, 128'(lat), 128'(el));
        check({tag, ".q"}, 128'(q8), 128'(eq));
        check({tag, ".r"}, 128'(r8), 128'(er));
        check({tag, ".dz"}, 128'(dz8), 128'(ez));
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, ".ir_after"}, 128'(ir8), 128'(1));
        check({tag, ".ov_after"}, 128'(ov8), 128'(0));
    endtask

    task automatic run64(input string tag, input logic [63:0] a,
                         input logic [63:0] b);
        int lat;
        logic [127:0] p;
        p = {64'b0, a} * {64'b0, b};
        iv64 = 1'b1;
        dd64 = p;
        dv64 = b;
        tick();
        iv64 = 1'b0;
        lat = 1;
        while (!ov64 && lat < 500) begin
            tick();
            lat++;
        end
        check({tag, ".lat"}, 128'(lat), 128'(129));
        check({tag, ".q"}, q64, {64'b0, a});
        check({tag, ".r"}, 128'(r64), 128'(0));
        or64 = 1'b1;
        tick();
        or64 = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] hq;
        logic [7:0]  hr;
        logic [63:0] a, b;

        tick();
        tick();
        rst = 1'b0;
        check("rst.ir", 128'(ir8), 128'(1));
        check("rst.ov", 128'(ov8), 128'(0));
        check("rst.q", 128'(q8), 128'(0));
        check("rst.r", 128'(r8), 128'(0));
        check("rst.dz", 128'(dz8), 128'(0));
        check("rst.ir64", 128'(ir64), 128'(1));

        run8("v391_23", 16'd391, 8'd23, 16'd17, 8'd0, 1'b0, 17);
        run8("vffff_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 17);
        run8("v1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
        run8("dz1234", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1);
        run8("v255_255", 16'd255, 8'd255, 16'd1, 8'd0, 1'b0, 17);
        run8("v100_200", 16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 17);
        run8("vffff_ff", 16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0, 17);
        run8("v50000_251", 16'd50000, 8'd251, 16'd199, 8'd51, 1'b0, 17);
        run8("dz0", 16'h0000, 8'd0, 16'hFFFF, 8'h00, 1'b1, 1);

        // Backpressure: result must sit unchanged while out_ready is low.
        issue8(16'd1000, 8'd7, lat);
        hq = q8;
        hr = r8;
        check("bp.q0", 128'(hq), 128'(142));
        repeat (5) tick();
        check("bp.ov", 128'(ov8), 128'(1));
        check("bp.ir", 128'(ir8), 128'(0));
        check("bp.q", 128'(q8), 128'(142));
        check("bp.r", 128'(r8), 128'(6));
        check("bp.dz", 128'(dz8), 128'(0));
        iv8 = 1'b1;
        dd8 = 16'd5;
        dv8 = 8'd1;
        tick();
        check("bp.ignore_in", 128'(q8), 128'(142));
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("bp.ir_next", 128'(ir8), 128'(1));
        check("bp.ov_next", 128'(ov8), 128'(0));

        // Outputs keep the last result while a new divide runs.
        iv8 = 1'b1;
        dd8 = 16'd391;
        dv8 = 8'd23;
        tick();
        iv8 = 1'b0;
        repeat (5) tick();
        check("run.hold_q", 128'(q8), 128'(142));
        check("run.ir", 128'(ir8), 128'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.ov", 128'(ov8), 128'(0));
        check("abort.ir", 128'(ir8), 128'(1));
        check("abort.q", 128'(q8), 128'(0));
        repeat (20) tick();
        check("abort.no_result", 128'(ov8), 128'(0));
        run8("post_rst", 16'd391, 8'd23, 16'd17, 8'd0, 1'b0, 17);

        // W=64 multiplier miter
        run64("m_ones_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run64("m_ones_ones", 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF);
        run64("m_zero_b", 64'd0, 64'd12345);
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) b = 64'($urandom);
            if (b == 0) b = 64'd3;
            run64($sformatf("m%0d", i), a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
